// File: rtl/serial_adder.sv
// Bit-serial adder: one fulladd cell plus a carry flop, consuming operands LSB-first
// over WIDTH cycles and presenting a registered parallel sum, carry-out and done pulse.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;

  fulladd u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c_in (carry),
    .s    (fa_s),
    .c_out(fa_c)
  );

  // Single-bit instances have no upper result bits to shift in from.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_s;
    end else begin : g_res_wn
      assign res_next = {fa_s, res_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      c_out  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= c_in;
            cnt    <= '0;
            res_sr <= '0;
            state  <= S_SHIFT;
            busy   <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_c;
          res_sr <= res_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum   <= res_next;
            c_out <= fa_c;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// 1-bit full adder cell.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 vector table plus corner sequences,
// and a WIDTH=1 instance swept against the full-adder truth table.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       reset1, start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .CNT_W(6)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_adder #(.WIDTH(1), .CNT_W(6)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one WIDTH=8 addition and wait (bounded) for its done pulse.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] s, output logic co, output int busy_cnt,
                      output logic ok);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) break;
      if (busy8) busy_cnt++;
      @(negedge clk);
    end
    ok = done8;
    s  = sum8;
    co = cout8;
  endtask

  task automatic add1(input logic a, input logic b, input logic c,
                      output logic s, output logic co, output int busy_cnt,
                      output logic ok);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done1) break;
      if (busy1) busy_cnt++;
      @(negedge clk);
    end
    ok = done1;
    s  = sum1;
    co = cout1;
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] s;
    logic       co, ok;
    int         bc, done_cnt, last_done, n_dones;
    logic [7:0] prev_sum;
    logic       s1, co1;
    logic [1:0] exp1;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[6] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h55, 8'h22, 1'b1, 8'h78, 1'b0};

    reset8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    reset1 = 1'b1; start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_sum", sum8, 8'h00);
    check("reset_cout", cout8, 0);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_busy_w1", busy1, 0);
    reset8 = 1'b0; reset1 = 1'b0;

    foreach (vecs[i]) begin
      add8(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, bc, ok);
      check($sformatf("vec%0d_done", i), ok, 1);
      check($sformatf("vec%0d_busy_cycles", i), bc, 8);
      check($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
      check($sformatf("vec%0d_cout", i), co, vecs[i].exp_cout);
    end

    // start pulsed while busy must be ignored
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 16; n++) begin
      if (n == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      if (n == 4) start8 = 1'b0;
      if (busy8) check("ignored_prev_sum_stable", sum8, 8'h78);
      if (done8) begin
        done_cnt++;
        check("ignored_sum", sum8, 8'h46);
        check("ignored_cout", cout8, 0);
      end
      @(negedge clk);
    end
    check("ignored_done_count", done_cnt, 1);

    // reset mid-operation discards the addition
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_busy_before", busy8, 1);
    reset8 = 1'b1;
    @(negedge clk);
    reset8 = 1'b0;
    check("midreset_busy", busy8, 0);
    check("midreset_sum", sum8, 8'h00);
    check("midreset_cout", cout8, 0);
    done_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (done8) done_cnt++;
      @(negedge clk);
    end
    check("midreset_no_done", done_cnt, 0);
    add8(8'h80, 8'h80, 1'b0, s, co, bc, ok);
    check("after_reset_done", ok, 1);
    check("after_reset_sum", s, 8'h00);
    check("after_reset_cout", co, 1);

    // start held high: back-to-back operations every WIDTH+1 cycles
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    prev_sum = 8'h00;
    last_done = -1;
    n_dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy8) check("b2b_sum_stable", sum8, prev_sum);
      if (done8) begin
        check("b2b_sum", sum8, 8'h03);
        check("b2b_cout", cout8, 0);
        if (last_done >= 0) check("b2b_interval", n - last_done, 9);
        last_done = n;
        n_dones++;
        prev_sum = 8'h03;
      end
    end
    start8 = 1'b0;
    check("b2b_done_count_min", (n_dones >= 4), 1);
    repeat (12) @(negedge clk);

    // WIDTH=1 truth-table sweep
    for (int v = 0; v < 8; v++) begin
      exp1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      add1(v[2], v[1], v[0], s1, co1, bc, ok);
      check($sformatf("w1_%0d_done", v), ok, 1);
      check($sformatf("w1_%0d_busy_cycles", v), bc, 1);
      check($sformatf("w1_%0d_sum", v), s1, exp1[0]);
      check($sformatf("w1_%0d_cout", v), co1, exp1[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
